// File: rtl/c3lib_tie_bus_chk_pkg.sv
// Shared types and defaults for the tied-bus receive checker.
// The optional error counter is controlled by C3LIB_TIE_BUS_CHK_ERRCNT_EN in the top.
package c3lib_tie_bus_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MON  = 2'd2,
    ERR  = 2'd3
  } tie_chk_state_e;

  localparam int unsigned DEF_ARM_CYC  = 32'd4;
  localparam int unsigned DEF_FILT_CNT = 32'd2;

  // Mismatches only matter once the bus has settled and is being watched.
  function automatic logic is_watching(input tie_chk_state_e s);
    return (s == MON) || (s == ERR);
  endfunction

endpackage

// File: rtl/c3lib_tie_bus_chk_filt.sv
// Consecutive-mismatch filter: counts back-to-back hits and pulses evt on the
// FILT_CNT-th one. A clear at the same edge suppresses the pulse and restarts.
module c3lib_tie_bus_chk_filt
  import c3lib_tie_bus_chk_pkg::*;
#(
  parameter int unsigned FILT_CNT = DEF_FILT_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hit,
  input  logic clr,
  output logic evt
);

  localparam int unsigned     FW   = (FILT_CNT > 32'd1) ? $clog2(FILT_CNT) : 32'd1;
  localparam logic [FW-1:0]   LAST = FW'(FILT_CNT - 32'd1);
  localparam logic [FW-1:0]   ONE  = FW'(32'd1);

  logic [FW-1:0] cnt_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign evt       = en & hit & at_last_s & ~clr;

  // Run length of consecutive mismatching samples; any break restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {FW{1'b0}};
    end else if (clr || !en || !hit || at_last_s) begin
      cnt_r <= {FW{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

endmodule

// File: rtl/c3lib_tie_bus_chk_lcell.sv
// Receive-side checker for a statically tied bus with filtered sticky error,
// per-bit capture and four-phase clear. Define C3LIB_TIE_BUS_CHK_ERRCNT_EN for err_cnt.
module c3lib_tie_bus_chk_lcell
  import c3lib_tie_bus_chk_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32'd4,
  parameter logic [WIDTH-1:0]  TIE_VALUE = WIDTH'(4'b0011),
  parameter int unsigned       ARM_CYC   = DEF_ARM_CYC,
  parameter int unsigned       FILT_CNT  = DEF_FILT_CNT,
  parameter int unsigned       CNT_W     = 32'd8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] in_bus,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [1:0]       state_o,
  output logic             err_live,
  output logic             err_sticky,
  output logic [WIDTH-1:0] err_bits,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned   AW       = (ARM_CYC > 32'd1) ? $clog2(ARM_CYC) : 32'd1;
  localparam logic [AW-1:0] ARM_LAST = AW'((ARM_CYC > 32'd0) ? ARM_CYC - 32'd1 : 32'd0);
  localparam logic [AW-1:0] ARM_ONE  = AW'(32'd1);

  tie_chk_state_e   state_r;
  logic [AW-1:0]    arm_cnt_r;
  logic [WIDTH-1:0] in_q_r;
  logic             clr_ack_r;
  logic             err_sticky_r;
  logic [WIDTH-1:0] err_bits_r;

  logic [WIDTH-1:0] mism_s;
  logic             any_mism_s;
  logic             watch_s;
  logic             clr_acc_s;
  logic             evt_s;

  assign mism_s     = in_q_r ^ TIE_VALUE;
  assign any_mism_s = |mism_s;
  assign watch_s    = is_watching(state_r);
  // Rising edge of the request as seen against our own ack: one clear per request.
  assign clr_acc_s  = clr_req & ~clr_ack_r;

  assign state_o    = state_r;
  assign err_live   = watch_s & any_mism_s;
  assign clr_ack    = clr_ack_r;
  assign err_sticky = err_sticky_r;
  assign err_bits   = err_bits_r;

  c3lib_tie_bus_chk_filt #(
    .FILT_CNT (FILT_CNT)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (watch_s & chk_en),
    .hit   (any_mism_s),
    .clr   (clr_acc_s),
    .evt   (evt_s)
  );

  // Input sample stage and clear acknowledge mirror.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q_r    <= {WIDTH{1'b0}};
      clr_ack_r <= 1'b0;
    end else begin
      in_q_r    <= in_bus;
      clr_ack_r <= clr_req;
    end
  end

  // Checker FSM with arm settle counter; dropping chk_en always returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      arm_cnt_r <= {AW{1'b0}};
    end else if (!chk_en) begin
      state_r   <= IDLE;
      arm_cnt_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          arm_cnt_r <= {AW{1'b0}};
          state_r   <= (ARM_CYC == 32'd0) ? MON : ARM;
        end
        ARM: begin
          if (arm_cnt_r == ARM_LAST) begin
            arm_cnt_r <= {AW{1'b0}};
            state_r   <= MON;
          end else begin
            arm_cnt_r <= arm_cnt_r + ARM_ONE;
          end
        end
        MON: begin
          if (evt_s) begin
            state_r <= ERR;
          end
        end
        ERR: begin
          if (clr_acc_s) begin
            state_r <= MON;
          end
        end
        default: begin
          state_r   <= IDLE;
          arm_cnt_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Sticky flag and per-bit capture; an accepted clear overrides new events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
      err_bits_r   <= {WIDTH{1'b0}};
    end else if (clr_acc_s) begin
      err_sticky_r <= 1'b0;
      err_bits_r   <= {WIDTH{1'b0}};
    end else begin
      if (evt_s) begin
        err_sticky_r <= 1'b1;
      end
      if (watch_s && any_mism_s) begin
        err_bits_r <= err_bits_r | mism_s;
      end
    end
  end

`ifdef C3LIB_TIE_BUS_CHK_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Saturating count of filtered error events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_acc_s) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (evt_s && (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/c3lib_tie_bus_chk_lcell.md
Name: c3lib_tie_bus_chk_lcell

Overview:
- Receive-side checker for a statically tied bus.
- Samples a bus that should hold the constant TIE_VALUE and filters mismatches over consecutive cycles.
- Raises a sticky error with per-bit capture; clearing uses a four-phase request/acknowledge.
- Used at die or IP boundaries to detect broken, floating or mis-strapped tie straps during DFT and bring-up.

Parameters:
- WIDTH, 4, checked bus width; >= 1.
- TIE_VALUE, 4'b0011, expected bus value, WIDTH bits.
- ARM_CYC, 4, settle cycles after chk_en rises before monitoring; 0 = monitor immediately.
- FILT_CNT, 2, consecutive mismatching samples needed for one error event; >= 1.
- CNT_W, 8, width of the error event counter.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- chk_en  input  1  level; enables checking.
- in_bus  input  WIDTH  bus under check; must be quasi-static or already synchronous to clk.
- clr_req  input  1  four-phase clear request.
- clr_ack  output  1  clear acknowledge.
- state_o  output  2  current FSM state.
- err_live  output  1  unfiltered mismatch of the registered sample.
- err_sticky  output  1  filtered sticky error.
- err_bits  output  WIDTH  sticky OR of mismatching bit positions.
- err_cnt  output  CNT_W  saturating error event count.

Behaviour:
- Reset (rst_n=0 at an edge): all flops clear. in_q=0, state=IDLE, filter=0, clr_ack=0, err_sticky=0, err_bits=0, err_cnt=0. err_live reads 0 while in IDLE.
- Input stage: in_q <= in_bus every edge. mism = in_q ^ TIE_VALUE. any_mism = |mism.
- err_live = any_mism when state is MON or ERR, otherwise 0.
- FSM states: IDLE=0, ARM=1, MON=2, ERR=3.
  - IDLE to ARM when chk_en=1. Goes straight to MON if ARM_CYC=0.
  - ARM counts ARM_CYC edges, ignores mismatches, then moves to MON.
  - MON to ERR when a filtered error event occurs.
  - ERR to MON on an accepted clear while chk_en=1.
  - From any state, chk_en=0 goes to IDLE. The filter and arm counter reset; sticky outputs are retained.
- Filter, active in MON and ERR only:
  - At an edge with any_mism=1, filter increments.
  - If filter == FILT_CNT-1 at that edge, it is an error event: err_sticky <= 1, filter <= 0, and err_cnt increments, saturating at all-ones.
  - At an edge with any_mism=0, filter <= 0.
- Latency: let edge k capture the first mismatching in_bus. With FILT_CNT consecutive mismatches, err_sticky is set at edge k+FILT_CNT.
- err_bits |= mism at every edge in MON or ERR where any_mism=1. Accumulation happens with or without a completed filter.
- Clear handshake:
  - clr_ack <= clr_req every edge.
  - An accepted clear is an edge where clr_req=1 and clr_ack=0. It zeroes err_sticky, err_bits, err_cnt and the filter.
  - Holding clr_req high causes exactly one clear.
  - A new clear requires clr_req low for at least one edge (clr_ack seen low).
- Simultaneous clear and error event: the clear wins. The filter restarts from 0 and a persisting mismatch re-flags after FILT_CNT further edges.
- chk_en falling mid-filter: the partial count is discarded. Re-enabling goes through ARM again.
- Reset mid-operation: same as power-on reset. No ack is pending after reset.

Optional Feature:
- Macro: C3LIB_TIE_BUS_CHK_ERRCNT_EN.
- Defined: err_cnt counter is implemented as above.
- Undefined: no counter flops; err_cnt is tied to 0. All other behaviour is unchanged.

Decomposition:
- Package c3lib_tie_bus_chk_pkg:
  - state enum tie_chk_state_e {IDLE, ARM, MON, ERR}, 2 bits.
  - default localparams for ARM_CYC and FILT_CNT.
- Sub-module c3lib_tie_bus_chk_filt: consecutive-match counter with sync clear; outputs the event pulse. Instantiated once.

Test Plan:
- Reset/idle: rst_n=0 for 3 edges, chk_en=0, in_bus=4'b1111 -> all outputs 0, state_o=0, err_live=0.
- Clean check: chk_en=1, in_bus=4'b0011 held 20 cycles -> state ARM for 4 edges then MON; err_sticky=0, err_cnt=0.
- Filtering:
  - In MON, in_bus=4'b0111 for 1 cycle -> err_live pulses, err_sticky stays 0, err_bits=4'b0100.
  - Then held 2 cycles -> err_sticky=1 at edge k+2, state ERR, err_cnt=1.
- Persistent fault: in_bus=4'b0001 held 10 cycles in ERR -> err_cnt=5, err_bits includes 4'b0010.
  - With CNT_W=2, 20 cycles -> err_cnt saturates at 3.
- Clear handshake:
  - clr_req held high 5 cycles -> one clear: outputs zeroed, clr_ack high the edge after clr_req rises and stays high while held.
  - Clear coinciding with a filter event -> err_sticky=0 after that edge.
- chk_en drop: deassert at filter=1 -> state IDLE, err_sticky retained.
  - Reassert with in_bus mismatching -> ARM for 4 edges before any new event.
  - Repeat the bench with the macro undefined -> err_cnt constant 0.
